// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: muxes icache/dcache read requests onto a single AXI read
// port with one transaction outstanding at most, and routes R beats back to
// the port that was granted.
// Optional feature macro: AXI_RD_ARB_RR_EN
//   defined   -> round-robin tie break (last-served port loses a tie; after reset icache wins)
//   undefined -> fixed priority, dcache wins ties
`timescale 1ns/1ps

module axi_rd_arbiter #(
    parameter int unsigned LINE_BEATS = 8,
    parameter logic [3:0]  I_ID       = 4'd0,
    parameter logic [3:0]  D_ID       = 4'd1
) (
    input  logic        clk,
    input  logic        resetn,
    // icache port
    input  logic        i_rd_req,
    input  logic [2:0]  i_rd_type,
    input  logic [31:0] i_rd_addr,
    output logic        i_rd_rdy,
    output logic        i_ret_valid,
    output logic        i_ret_last,
    output logic [31:0] i_ret_data,
    // dcache port
    input  logic        d_rd_req,
    input  logic [2:0]  d_rd_type,
    input  logic [31:0] d_rd_addr,
    output logic        d_rd_rdy,
    output logic        d_ret_valid,
    output logic        d_ret_last,
    output logic [31:0] d_ret_data,
    // AXI AR channel
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    // AXI R channel
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    // status
    output logic        rd_err
);

    localparam int unsigned LENW     = 8;
    localparam int unsigned CNTW     = 3;
    localparam logic [LENW-1:0] LINE_LEN = LENW'(LINE_BEATS - 1);
    localparam logic [2:0] TYPE_BYTE = 3'b000;
    localparam logic [2:0] TYPE_HALF = 3'b001;
    localparam logic [2:0] TYPE_LINE = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t            state;
    logic              grant_d;     // latched grant: 1 = dcache, 0 = icache
    logic [CNTW-1:0]   beat_cnt;

    logic              pick_d;
    logic              accept;
    logic              beat;
    logic [2:0]        sel_type;
    logic [31:0]       sel_addr;
    logic [LENW-1:0]   sel_len;
    logic [2:0]        sel_size;
    logic              unused_rid;

    // rid carries no routing information here; routing uses the latched grant
    assign unused_rid = ^rid;

`ifdef AXI_RD_ARB_RR_EN
    logic last_d;                   // port served most recently was dcache

    // Round-robin tie break: the port served last loses a tie
    always_comb begin
        pick_d = d_rd_req & (~i_rd_req | ~last_d);
    end
`else
    // Fixed priority: dcache wins whenever it is requesting
    always_comb begin
        pick_d = d_rd_req;
    end
`endif

    // Request handshake: only the port chosen this cycle sees rd_rdy in IDLE
    assign i_rd_rdy = resetn & (state == IDLE) & i_rd_req & ~pick_d;
    assign d_rd_rdy = resetn & (state == IDLE) & pick_d;
    assign accept   = i_rd_rdy | d_rd_rdy;

    // Return path: steer the R channel to the granted port only
    assign beat        = rvalid & rready;
    assign i_ret_valid = beat & ~grant_d;
    assign d_ret_valid = beat & grant_d;
    assign i_ret_last  = rlast & rready & ~grant_d;
    assign d_ret_last  = rlast & rready & grant_d;
    assign i_ret_data  = rdata;
    assign d_ret_data  = rdata;
    assign arburst     = 2'b01;

    // Decode the winning request into AR fields
    always_comb begin
        sel_type = pick_d ? d_rd_type : i_rd_type;
        sel_addr = pick_d ? d_rd_addr : i_rd_addr;
        sel_len  = (sel_type == TYPE_LINE) ? LINE_LEN : '0;
        case (sel_type)
            TYPE_BYTE: sel_size = 3'd0;
            TYPE_HALF: sel_size = 3'd1;
            default:   sel_size = 3'd2;
        endcase
    end

    // Transaction FSM with registered AR/R control and sticky length check
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            grant_d  <= 1'b0;
            beat_cnt <= '0;
            arid     <= '0;
            araddr   <= '0;
            arlen    <= '0;
            arsize   <= '0;
            arvalid  <= 1'b0;
            rready   <= 1'b0;
            rd_err   <= 1'b0;
`ifdef AXI_RD_ARB_RR_EN
            last_d   <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        grant_d <= pick_d;
                        araddr  <= sel_addr;
                        arlen   <= sel_len;
                        arsize  <= sel_size;
                        arid    <= pick_d ? D_ID : I_ID;
                        arvalid <= 1'b1;
                        state   <= ADDR;
`ifdef AXI_RD_ARB_RR_EN
                        last_d  <= pick_d;
`endif
                    end
                end
                ADDR: begin
                    if (arready) begin
                        arvalid  <= 1'b0;
                        rready   <= 1'b1;
                        beat_cnt <= '0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + CNTW'(1);
                        if (rlast != (LENW'(beat_cnt) == arlen)) begin
                            rd_err <= 1'b1;
                        end
                        if (rlast) begin
                            rready <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end
                default: begin
                    arvalid <= 1'b0;
                    rready  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: directed scenarios plus randomized
// request traffic checked against a transaction-level reference model.
`timescale 1ns/1ps

module tb_axi_rd_arbiter;

    localparam int LB = 8;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_rd_req, d_rd_req;
    logic [2:0]  i_rd_type, d_rd_type;
    logic [31:0] i_rd_addr, d_rd_addr;
    logic        i_rd_rdy, d_rd_rdy;
    logic        i_ret_valid, d_ret_valid, i_ret_last, d_ret_last;
    logic [31:0] i_ret_data, d_ret_data;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rlast, rvalid, rready, rd_err;

    int checks   = 0;
    int failures = 0;

    // reference model state
    bit last_d_m = 1'b1;   // most recently served port was dcache (reset: icache wins ties)
    bit err_m    = 1'b0;

    logic [2:0] type_tbl [4] = '{3'b000, 3'b001, 3'b010, 3'b100};

    always #5 clk = ~clk;

    axi_rd_arbiter #(.LINE_BEATS(LB), .I_ID(4'd0), .D_ID(4'd1)) dut (
        .clk(clk), .resetn(resetn),
        .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr),
        .i_rd_rdy(i_rd_rdy), .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last),
        .i_ret_data(i_ret_data),
        .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr),
        .d_rd_rdy(d_rd_rdy), .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last),
        .d_ret_data(d_ret_data),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .rd_err(rd_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit winner_d(input bit ireq, input bit dreq);
        if (!dreq) return 1'b0;
        if (!ireq) return 1'b1;
`ifdef AXI_RD_ARB_RR_EN
        return !last_d_m;
`else
        return 1'b1;
`endif
    endfunction

    function automatic int exp_len(input logic [2:0] t);
        return (t == 3'b100) ? LB - 1 : 0;
    endfunction

    function automatic int exp_size(input logic [2:0] t);
        if (t == 3'b000) return 0;
        if (t == 3'b001) return 1;
        return 2;
    endfunction

    // Serve one transaction for port pd (1 = dcache) whose request is already driven.
    // last_at = beat number carrying rlast (0 = natural burst length).
    task automatic serve(input bit pd, input int ar_delay, input int last_at,
                         input int gap_max, input bit fixed, input logic [31:0] fdata);
        logic [2:0]  t;
        logic [31:0] a, d;
        int len, nb, idx;
        bit lst;
        t   = pd ? d_rd_type : i_rd_type;
        a   = pd ? d_rd_addr : i_rd_addr;
        len = exp_len(t);
        nb  = (last_at == 0) ? len + 1 : last_at;
        #1;
        chk("rdy_winner", pd ? d_rd_rdy : i_rd_rdy, 1);
        chk("rdy_loser",  pd ? i_rd_rdy : d_rd_rdy, 0);
        @(posedge clk); #1;
        if (pd) d_rd_req = 1'b0; else i_rd_req = 1'b0;
        last_d_m = pd;
        #1;
        chk("arvalid_set", arvalid, 1);
        chk("araddr", araddr, a);
        chk("arlen", arlen, len);
        chk("arsize", arsize, exp_size(t));
        chk("arburst", arburst, 1);
        chk("arid", arid, pd ? 1 : 0);
        chk("rdy_busy_i", i_rd_rdy, 0);
        chk("rdy_busy_d", d_rd_rdy, 0);
        for (int k = 0; k < ar_delay; k++) begin
            @(posedge clk); #1;
            chk("arvalid_hold", arvalid, 1);
            chk("araddr_hold", araddr, a);
            chk("arlen_hold", arlen, len);
        end
        arready = 1'b1;
        @(posedge clk); #1;
        arready = 1'b0;
        #1;
        chk("arvalid_clr", arvalid, 0);
        chk("rready_data", rready, 1);
        for (int b = 1; b <= nb; b++) begin
            int g;
            g = $urandom_range(0, gap_max);
            for (int k = 0; k < g; k++) begin
                rvalid = 1'b0; rlast = 1'b0;
                #1;
                chk("gap_ret_i", i_ret_valid, 0);
                chk("gap_ret_d", d_ret_valid, 0);
                @(posedge clk); #1;
            end
            lst    = (b == nb);
            d      = fixed ? fdata + 32'(b - 1) : $urandom;
            rvalid = 1'b1; rlast = lst; rdata = d; rid = 4'($urandom);
            #1;
            chk("ret_valid_own",   pd ? d_ret_valid : i_ret_valid, 1);
            chk("ret_valid_other", pd ? i_ret_valid : d_ret_valid, 0);
            chk("ret_last",        pd ? d_ret_last  : i_ret_last, lst);
            chk("ret_data",        pd ? d_ret_data  : i_ret_data, d);
            idx = (b - 1) % 8;
            if (lst != (idx == len)) err_m = 1'b1;
            @(posedge clk); #1;
            rvalid = 1'b0; rlast = 1'b0;
            chk("rd_err", rd_err, err_m);
        end
        #1;
        chk("rready_idle", rready, 0);
    endtask

    initial begin
        bit w1, w2, w3, pd;
        int pat;
        resetn = 1'b0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
        rdata = '0; rid = '0;
        i_rd_req = 1'b1; d_rd_req = 1'b1;
        i_rd_type = 3'b010; d_rd_type = 3'b010;
        i_rd_addr = '0; d_rd_addr = '0;
        #2;
        // reset state
        chk("rst_i_rdy", i_rd_rdy, 0);
        chk("rst_d_rdy", d_rd_rdy, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_rd_err", rd_err, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_arlen", arlen, 0);
        chk("rst_arsize", arsize, 0);
        chk("rst_arid", arid, 0);
        i_rd_req = 1'b0; d_rd_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); resetn = 1'b1;

        // single icache word fetch
        @(negedge clk);
        i_rd_req = 1'b1; i_rd_type = 3'b010; i_rd_addr = 32'h1FC0_0000;
        serve(1'b0, 0, 0, 0, 1'b1, 32'h3C08_BFAF);

        // dcache line refill, data 0..7
        @(negedge clk);
        d_rd_req = 1'b1; d_rd_type = 3'b100; d_rd_addr = 32'h0000_1000;
        serve(1'b1, 0, 0, 1, 1'b1, 32'h0);

        // back-to-back ties: winner re-requests immediately
        @(negedge clk);
        i_rd_req = 1'b1; d_rd_req = 1'b1;
        i_rd_type = 3'b010; d_rd_type = 3'b001;
        i_rd_addr = 32'h1FC0_0004; d_rd_addr = 32'h0000_2002;
        w1 = winner_d(1'b1, 1'b1);
`ifdef AXI_RD_ARB_RR_EN
        chk("tie1_winner", {31'b0, w1}, 0);
`else
        chk("tie1_winner", {31'b0, w1}, 1);
`endif
        serve(w1, 0, 0, 0, 1'b0, 32'h0);
        if (w1) d_rd_req = 1'b1; else i_rd_req = 1'b1;
        w2 = winner_d(1'b1, 1'b1);
        chk("tie2_winner", {31'b0, w2}, 1);
        serve(w2, 0, 0, 0, 1'b0, 32'h0);
        w3 = winner_d(i_rd_req, d_rd_req);
        serve(w3, 0, 0, 0, 1'b0, 32'h0);

        // arready held off for 5 cycles
        @(negedge clk);
        d_rd_req = 1'b1; d_rd_type = 3'b100; d_rd_addr = 32'h0000_3000;
        serve(1'b1, 5, 0, 0, 1'b0, 32'h0);

        // randomized traffic
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            pat = $urandom_range(0, 2);
            i_rd_type = type_tbl[$urandom_range(0, 3)];
            d_rd_type = type_tbl[$urandom_range(0, 3)];
            i_rd_addr = $urandom; d_rd_addr = $urandom;
            i_rd_req = (pat != 1); d_rd_req = (pat != 0);
            for (int k = 0; k < 2 && (i_rd_req || d_rd_req); k++) begin
                pd = winner_d(i_rd_req, d_rd_req);
                serve(pd, $urandom_range(0, 3), 0, 2, 1'b0, 32'h0);
            end
        end

        // early rlast on beat 4 of a line, then a clean burst: error is sticky
        @(negedge clk);
        d_rd_req = 1'b1; d_rd_type = 3'b100; d_rd_addr = 32'h0000_4000;
        serve(1'b1, 0, 4, 0, 1'b0, 32'h0);
        chk("err_after_short", rd_err, 1);
        @(negedge clk);
        i_rd_req = 1'b1; i_rd_type = 3'b100; i_rd_addr = 32'h0000_5000;
        serve(1'b0, 1, 0, 0, 1'b0, 32'h0);
        chk("err_sticky", rd_err, 1);

        // reset pulse mid-burst
        @(negedge clk);
        d_rd_req = 1'b1; d_rd_type = 3'b100; d_rd_addr = 32'h0000_6000;
        @(posedge clk); #1;
        d_rd_req = 1'b0; arready = 1'b1;
        @(posedge clk); #1;
        arready = 1'b0; rvalid = 1'b1; rlast = 1'b0; rdata = 32'hDEAD_0001;
        #1;
        chk("mid_beat_valid", d_ret_valid, 1);
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        err_m = 1'b0; last_d_m = 1'b1;
        chk("midrst_arvalid", arvalid, 0);
        chk("midrst_rready", rready, 0);
        chk("midrst_rd_err", rd_err, 0);
        chk("midrst_d_ret", d_ret_valid, 0);
        chk("midrst_araddr", araddr, 0);
        @(negedge clk); resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("post_rst_d_ret", d_ret_valid, 0);
            chk("post_rst_i_ret", i_ret_valid, 0);
            chk("post_rst_arvalid", arvalid, 0);
        end
        rvalid = 1'b0;

        // recovery: tie after reset resolves as after power-up
        @(negedge clk);
        i_rd_req = 1'b1; d_rd_req = 1'b1;
        i_rd_type = 3'b000; d_rd_type = 3'b010;
        i_rd_addr = 32'h1FC0_0100; d_rd_addr = 32'h0000_7000;
        for (int k = 0; k < 2 && (i_rd_req || d_rd_req); k++) begin
            pd = winner_d(i_rd_req, d_rd_req);
            serve(pd, 0, 0, 0, 1'b0, 32'h0);
        end
        chk("final_rd_err", rd_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 Parameter LINE_BEATS, default 8: beats per cache-line refill (rd_type 3'b100); arlen = LINE_BEATS-1.
REQ-002 Parameter I_ID, default 4'd0: arid driven for icache transactions.
REQ-003 Parameter D_ID, default 4'd1: arid driven for dcache transactions.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 i_rd_req / d_rd_req  in  1  icache / dcache read request, held until accepted.
REQ-007 i_rd_type / d_rd_type  in  3  000 byte, 001 half, 010 word, 100 line.
REQ-008 i_rd_addr / d_rd_addr  in  32  physical read address.
REQ-009 i_rd_rdy / d_rd_rdy  out  1  request accepted this cycle when high with rd_req.
REQ-010 i_ret_valid / d_ret_valid  out  1  return beat valid for that port.
REQ-011 i_ret_last / d_ret_last  out  1  final beat of burst.
REQ-012 i_ret_data / d_ret_data  out  32  return data.
REQ-013 arid 4, araddr 32, arlen 8, arsize 3, arburst 2, arvalid 1  out  AXI AR channel.
REQ-014 arready  in  1  AXI AR accept.
REQ-015 rid 4, rdata 32, rlast 1, rvalid 1  in  AXI R channel.
REQ-016 rready  out  1  AXI R accept.
REQ-017 rd_err  out  1  sticky burst-length mismatch flag.

Function
REQ-018 The FSM SHALL have states IDLE, ADDR, DATA; one transaction outstanding at most.
REQ-019 In IDLE, x_rd_rdy SHALL be high combinationally only for the port granted this cycle; the other port's rd_rdy low.
REQ-020 Request accept (rd_req & rd_rdy in IDLE) SHALL latch grant, addr, type and move to ADDR next cycle (arvalid high one cycle after accept).
REQ-021 In ADDR, arvalid SHALL be 1 and araddr/arlen/arsize/arburst/arid SHALL be stable until arready; on arvalid & arready move to DATA.
REQ-022 arlen SHALL be LINE_BEATS-1 for type 100 and 0 otherwise; arsize 0/1/2 for byte/half/(word or line); arburst 2'b01 (INCR).
REQ-023 In DATA, rready SHALL be 1; elsewhere 0.
REQ-024 Granted port's ret_valid = rvalid & rready; ret_last = rlast; ret_data = rdata, all combinational; ungranted port ret_valid = 0.
REQ-025 3-bit beat counter SHALL clear on entering DATA and increment per accepted beat; on accepted beat with rlast, FSM SHALL return to IDLE next cycle.
REQ-026 rd_err SHALL set if rlast arrives with counter != arlen, or a non-last beat arrives with counter == arlen; it stays set until reset.
REQ-027 rid SHALL be ignored for routing; routing uses the latched grant only.
REQ-028 Simultaneous i_rd_req and d_rd_req in IDLE SHALL be resolved per REQ-033; the loser stays pending and is served next IDLE.
REQ-029 Requests arriving outside IDLE SHALL see rd_rdy = 0 and are not lost (requester holds).

Reset
REQ-030 resetn low SHALL immediately force IDLE, arvalid 0, rready 0, rd_err 0, counter 0, grant to icache, all rd_rdy/ret_valid 0.
REQ-031 Reset mid-burst SHALL abandon the transaction; no beats delivered after reset deassertion.
REQ-032 araddr/arlen/arsize/arid SHALL reset to 0.

Configuration
REQ-033 Macro AXI_RD_ARB_RR_EN: defined -> round-robin, last-served port loses a tie (after reset icache has priority); undefined -> fixed priority, dcache always wins ties.

Verification
REQ-034 i_rd_req word 0x1FC0_0000 alone -> i_rd_rdy same cycle, next cycle arvalid, arlen 0, arsize 2, arid 0; one beat rdata 0x3C08BFAF -> i_ret_valid/i_ret_last 1, data 0x3C08BFAF, back to IDLE.
REQ-035 d_rd_req line 0x0000_1000 -> arlen 7, arsize 2, arid 1; 8 beats 0..7 with rlast on 8th -> d_ret_valid x8, d_ret_last on 8th only, rd_err 0.
REQ-036 Both requests same cycle, macro undefined -> dcache granted; icache granted after dcache rlast; with macro defined, two back-to-back ties alternate icache, dcache.
REQ-037 arready held low 5 cycles -> araddr/arlen stable, arvalid held; accept on 6th cycle -> DATA.
REQ-038 Line burst with rlast on beat 4 -> rd_err 1 and remains 1; resetn pulse mid-burst -> IDLE, arvalid 0, rd_err 0.
